// File: rtl/bask_pkg.sv
// Shared types and sizing helpers for the BASK receive path.
package bask_pkg;

  localparam int unsigned SAMPLE_W_DEFAULT = 8;
  localparam int unsigned WORD_W           = 8;
  localparam int unsigned BIT_IDX_W        = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Accumulator holds a full bit period of maximum-magnitude samples.
  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned samples_per_bit);
    return sample_w + $clog2(samples_per_bit);
  endfunction

endpackage

// File: rtl/bask_bit_integrator.sv
// Integrates |sample| over one bit period and decides the bit against a threshold.
module bask_bit_integrator
  import bask_pkg::*;
#(
  parameter int unsigned SAMPLE_W        = SAMPLE_W_DEFAULT,
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned THRESHOLD       = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       run,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic                       bit_c,
  output logic                       done_c
);

  localparam int unsigned ACC_W = acc_width(SAMPLE_W, SAMPLES_PER_BIT);
  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_BIT);

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt;
  logic                last;

  // Most negative input maps to 2^(SAMPLE_W-1), which still fits unsigned.
  always_comb begin
    mag    = sample_in[SAMPLE_W-1] ? SAMPLE_W'(~sample_in + 1'b1) : $unsigned(sample_in);
    sum    = acc + ACC_W'(mag);
    last   = (cnt == CNT_W'(SAMPLES_PER_BIT - 1));
    done_c = run && !start && sample_valid && last;
    bit_c  = (32'(sum) >= THRESHOLD);
  end

  // A start with a valid sample makes that sample the first of the new bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= sample_valid ? ACC_W'(mag) : '0;
      cnt <= sample_valid ? CNT_W'(1) : '0;
    end else if (run && sample_valid) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bask_demodulator.sv
// BASK demodulator: bit integration, MSB-first word assembly and valid strobes.
// Optional BASK_DEMOD_PARITY_EN adds an even-parity bit period and parity_err output.
module bask_demodulator
  import bask_pkg::*;
#(
  parameter int unsigned SAMPLE_W        = SAMPLE_W_DEFAULT,
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned THRESHOLD       = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       frame_start,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic [WORD_W-1:0]          data_out,
  output logic                       data_valid
`ifdef BASK_DEMOD_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

`ifdef BASK_DEMOD_PARITY_EN
  localparam int unsigned SHREG_W = WORD_W;
`else
  localparam int unsigned SHREG_W = WORD_W - 1;
`endif

  state_t               state;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [SHREG_W-1:0]   shreg;
  logic                 run;
  logic                 bit_c;
  logic                 done_c;

  assign run = (state != IDLE);

  bask_bit_integrator #(
    .SAMPLE_W        (SAMPLE_W),
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .THRESHOLD       (THRESHOLD)
  ) u_integrator (
    .clk          (clk),
    .reset        (reset),
    .start        (frame_start),
    .run          (run),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .bit_c        (bit_c),
    .done_c       (done_c)
  );

  // frame_start has priority in every state so an aborted word never completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef BASK_DEMOD_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      bit_valid  <= 1'b0;
      data_valid <= 1'b0;
      if (frame_start) begin
        state   <= ACCUM;
        bit_idx <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (done_c) begin
              bit_out   <= bit_c;
              bit_valid <= 1'b1;
              shreg     <= {shreg[SHREG_W-2:0], bit_c};
              if (bit_idx == BIT_IDX_W'(WORD_W - 1)) begin
`ifdef BASK_DEMOD_PARITY_EN
                state      <= PARITY;
`else
                data_out   <= {shreg, bit_c};
                data_valid <= 1'b1;
                state      <= IDLE;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
`ifdef BASK_DEMOD_PARITY_EN
          PARITY: begin
            if (done_c) begin
              bit_out    <= bit_c;
              bit_valid  <= 1'b1;
              data_out   <= shreg;
              data_valid <= 1'b1;
              parity_err <= (^shreg) ^ bit_c;
              state      <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bask_demodulator.sv
// Scoreboard bench for bask_demodulator: expected bits/words queued at stimulus time.
module tb_bask_demodulator;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic              frame_start;
  logic              bit_out;
  logic              bit_valid;
  logic [7:0]        data_out;
  logic              data_valid;
`ifdef BASK_DEMOD_PARITY_EN
  logic              parity_err;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   gcyc     = 0;
  bit   gaps     = 1'b0;
  logic exp_bits[$];
  int   exp_words[$];

  bask_demodulator dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_start  (frame_start),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .data_out     (data_out),
    .data_valid   (data_valid)
`ifdef BASK_DEMOD_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample; in gap mode every third cycle is an invalid filler cycle.
  task automatic put(input logic signed [7:0] s);
    if (gaps && (gcyc % 3 == 2)) begin
      sample_valid = 1'b0;
      sample_in    = 8'sh7f;
      tick();
      gcyc++;
      frame_start = 1'b0;
    end
    sample_valid = 1'b1;
    sample_in    = s;
    tick();
    gcyc++;
    sample_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic put_const(input logic signed [7:0] s, input logic exp_bit);
    exp_bits.push_back(exp_bit);
    for (int i = 0; i < 16; i++) put(s);
  endtask

  task automatic put_bit(input logic b);
    exp_bits.push_back(b);
    for (int i = 0; i < 16; i++)
      put(b ? ((i % 2) ? -8'sd100 : 8'sd100) : 8'sd0);
  endtask

  // Full word; flip inverts the transmitted parity bit when parity is built in.
  task automatic send_word(input logic [7:0] w, input bit same_cycle, input logic flip);
    logic [8:0] ew;
    ew = {flip, w};
`ifndef BASK_DEMOD_PARITY_EN
    ew[8] = 1'b0;
`endif
    exp_words.push_back(int'(ew));
    frame_start = 1'b1;
    if (!same_cycle) begin
      tick();
      frame_start = 1'b0;
    end
    for (int i = 7; i >= 0; i--) put_bit(w[i]);
`ifdef BASK_DEMOD_PARITY_EN
    put_bit((^w) ^ flip);
`endif
    check("dv_latency", 32'(data_valid), 32'd1);
    check("dout_at_dv", 32'(data_out), 32'(w));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        if (exp_bits.size() == 0) check("unexpected_bit_valid", 32'(bit_valid), 32'd0);
        else check("bit", 32'(bit_out), 32'(exp_bits.pop_front()));
      end
      if (data_valid) begin
        check("dv_with_bv", 32'(bit_valid), 32'd1);
        if (exp_words.size() == 0) check("unexpected_data_valid", 32'(data_valid), 32'd0);
        else begin
          int e;
          e = exp_words.pop_front();
          check("word", 32'(data_out), 32'(e[7:0]));
`ifdef BASK_DEMOD_PARITY_EN
          check("parity_err", 32'(parity_err), 32'(e[8]));
`endif
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    tick();
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
`ifdef BASK_DEMOD_PARITY_EN
    check("rst_parity_err", 32'(parity_err), 32'd0);
`endif
    tick();
    reset = 1'b0;
    tick();

    // Samples while idle are ignored.
    for (int i = 0; i < 20; i++) put(8'sd100);
    check("idle_no_bit", 32'(bit_valid), 32'd0);

    // frame_start alone, then 128 samples.
    send_word(8'h89, 1'b0, 1'b0);

    // Threshold boundary: 512 -> 1, 496 -> 0, 2048 -> 1.
    exp_words.push_back(32'h0A0);
    frame_start = 1'b1;
    put_const(8'sd32, 1'b1);
    put_const(-8'sd31, 1'b0);
    put_const(-8'sd128, 1'b1);
    for (int i = 0; i < 5; i++) put_const(8'sd0, 1'b0);
`ifdef BASK_DEMOD_PARITY_EN
    put_const(8'sd0, 1'b0);
`endif
    check("thr_dv", 32'(data_valid), 32'd1);
    check("thr_dout", 32'(data_out), 32'h0A0);

    // Hold after completion.
    tick(); tick(); tick();
    check("hold_dout", 32'(data_out), 32'h0A0);
    check("hold_dv_low", 32'(data_valid), 32'd0);

    // sample_valid gaps.
    gaps = 1'b1;
    gcyc = 0;
    send_word(8'hA5, 1'b1, 1'b0);
    gaps = 1'b0;

    // Abort after 3 bits of 0xFF, restart back-to-back with 0x3C.
    frame_start = 1'b1;
    for (int i = 0; i < 3; i++) put_bit(1'b1);
    send_word(8'h3C, 1'b1, 1'b0);
    // Back-to-back start in the data_valid cycle.
    send_word(8'h5A, 1'b1, 1'b0);

    // Reset at sample 70 of a word.
    frame_start = 1'b1;
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
    for (int i = 0; i < 6; i++) put(8'sd100);
    reset = 1'b1;
    #2;
    check("midrst_bit_out", 32'(bit_out), 32'd0);
    check("midrst_bit_valid", 32'(bit_valid), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_data_valid", 32'(data_valid), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    send_word(8'hC3, 1'b0, 1'b0);

`ifdef BASK_DEMOD_PARITY_EN
    send_word(8'h89, 1'b1, 1'b1);
    send_word(8'h89, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 5; i++) tick();
    check("bits_drained", 32'(exp_bits.size()), 32'd0);
    check("words_drained", 32'(exp_words.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
